alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Registered, parametrised successor to the single-cycle 16-bit saturating ALU in the execute stage.
- Generalises data width.
- Adds a valid/ready handshake on input and output.
- Adds an internal committed flags register {N,Z,V}.
- Adds a multi-cycle saturating signed multiply (MUL) built from an iterative shift-add FSM.
- Sits between the decode/register-read stage and writeback.

Parameters:
- WIDTH, 16, datapath width in bits; even, ≥8.
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted this cycle when in_valid & in_ready.
- src0  in  WIDTH  operand A.
- src1  in  WIDTH  operand B.
- alu_op  in  4  opcode (ALU_* constants).
- sh_amt  in  SHW  shift amount.
- upd_flags_on_add  in  1  ADD updates flags when 1.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer takes result when out_valid & out_ready.
- dst  out  WIDTH  result.
- flags  out  3  committed {N,Z,V}.
- busy  out  1  MUL in progress.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; out_valid=0, dst=0, flags=3'b000, busy=0.
  - Any in-flight MUL is discarded.
  - Outputs are valid in the same cycle reset asserts.
- in_ready = (state==IDLE) & (~out_valid | out_ready). This permits a back-to-back accept in the cycle the previous result drains.
- Single-cycle ops, accepted at edge T: dst/flags/out_valid update at edge T+1.
  - ADD, SUB: signed saturating.
    - Positive overflow gives 2^(W-1)-1; negative overflow gives -2^(W-1); V=1.
    - SUB overflow is true signed overflow of src0-src1, including src1 = -2^(W-1).
  - AND: src0 & src1.
  - NOR: ~(src0|src1).
  - SLL: logical shift left by sh_amt.
  - SRL: logical shift right by sh_amt.
  - SRA: arithmetic shift right by sh_amt, sign-filled.
  - LHB: {src1[W/2-1:0], src0[W/2-1:0]}.
  - NOP: dst keeps its previous value; flags unchanged; still produces one output beat.
  - Undefined opcode: dst=0; flags unchanged; one output beat.
- Flag update, applied at the same edge dst loads:
  - Z=(dst==0) for ADD(upd=1), SUB, AND, NOR, SLL, SRL, SRA, MUL.
  - N=dst[W-1] and V=overflow for ADD(upd=1), SUB, MUL.
  - All other cases hold the previous flag bit. ADD with upd=0 holds all flags.
- MUL FSM: IDLE -> MUL -> IDLE.
  - On accept, latch |src0|, |src1| as unsigned W-bit values (|-2^(W-1)| = 2^(W-1) fits) and the result sign = src0[W-1]^src1[W-1]. Clear the 2W-bit accumulator and a counter.
  - In MUL, one multiplier bit per cycle for WIDTH cycles; busy=1; in_ready=0.
  - On the last iteration, apply the sign and saturate:
    - Positive magnitude > 2^(W-1)-1 gives max, V=1.
    - Negative magnitude > 2^(W-1) gives min, V=1.
    - Otherwise truncate the signed product, V=0.
  - Load dst/flags and set out_valid. Accepted at edge T gives out_valid at edge T+WIDTH+1.
  - A zero operand does not shorten latency.
  - A MUL cannot start while the output register holds an unconsumed result.
- Output hold: while out_valid & ~out_ready, dst and flags are stable and no new op is accepted.
- out_valid clears on consumption unless a new result loads in the same edge.

Decomposition:
- ALU_* opcodes, including the new ALU_MUL (4'hA), go in the shared defines.v.
- Flag bit indices (FLAG_N=2, FLAG_Z=1, FLAG_V=0) go in the shared defines.v.
- Sub-module alu_sat_comb: purely combinational single-cycle op evaluation plus the overflow/saturation logic, parametrised by WIDTH.
- alu_pipe holds the FSM, the multiplier datapath, and the output and flag registers.

Test Plan (WIDTH=16):
1. ADD 0x7000+0x2000, upd=1, out_ready=1 -> next cycle dst=0x7FFF, flags N=0 Z=0 V=1. Then ADD 0x0001+0xFFFF with upd=0 -> dst=0x0000, flags unchanged (N=0 Z=0 V=1).
2. SUB 0x8000-0x0001 -> dst=0x8000, N=1 V=1. SUB 0x0000-0x8000 -> dst=0x7FFF, N=0 V=1.
3. MUL 0xFFFD*0x0005 -> out_valid exactly 17 cycles after accept, dst=0xFFF1, N=1 Z=0 V=0; busy=1 and in_ready=0 throughout. MUL 0x0100*0x0100 -> dst=0x7FFF, V=1. MUL 0x8000*0xFFFF -> dst=0x7FFF, V=1.
4. SRA 0x8000 by 15 -> 0xFFFF, Z=0, N/V held. LHB src0=0x12AB, src1=0x34CD -> dst=0xCDAB, flags held.
5. Backpressure: out_ready=0 for 5 cycles after AND result -> dst/flags stable, in_ready=0. Raise out_ready with in_valid high -> result drains and the next op is accepted in the same cycle.
6. Assert rst_n=0 mid-MUL (cycle 8) -> out_valid=0, dst=0, flags=0, busy=0 immediately. After release a new ADD completes normally with 1-cycle latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared opcodes, flag indices and FSM states for the pipelined ALU.
// Imported by alu_sat_comb and alu_pipe.
package alu_pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_NOR = 4'h3;
  localparam logic [3:0] ALU_SLL = 4'h4;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SRA = 4'h6;
  localparam logic [3:0] ALU_LHB = 4'h7;
  localparam logic [3:0] ALU_NOP = 4'h8;
  localparam logic [3:0] ALU_MUL = 4'hA;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_sat_comb.sv
// Combinational single-cycle ALU ops with signed saturation.
// Reports which flag groups the op is allowed to update.
module alu_sat_comb
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   sh_amt,
  input  logic             upd_add,
  output logic [WIDTH-1:0] res,
  output logic             keep_dst,
  output logic             upd_nv,
  output logic             upd_z,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sat;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum  = a + b;
  assign diff = a - b;
  // Overflow always saturates toward the sign of operand A.
  assign sat  = a[WIDTH-1] ? SMIN : SMAX;

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &
                   (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &
                   (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res      = '0;
    keep_dst = 1'b0;
    upd_nv   = 1'b0;
    upd_z    = 1'b0;
    ovf      = 1'b0;
    unique case (op)
      ALU_ADD: begin
        res    = add_ovf ? sat : sum;
        upd_nv = upd_add;
        upd_z  = upd_add;
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        res    = sub_ovf ? sat : diff;
        upd_nv = 1'b1;
        upd_z  = 1'b1;
        ovf    = sub_ovf;
      end
      ALU_AND: begin
        res   = a & b;
        upd_z = 1'b1;
      end
      ALU_NOR: begin
        res   = ~(a | b);
        upd_z = 1'b1;
      end
      ALU_SLL: begin
        res   = a << sh_amt;
        upd_z = 1'b1;
      end
      ALU_SRL: begin
        res   = a >> sh_amt;
        upd_z = 1'b1;
      end
      ALU_SRA: begin
        res   = $signed(a) >>> sh_amt;
        upd_z = 1'b1;
      end
      ALU_LHB: begin
        res = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]};
      end
      ALU_NOP: begin
        keep_dst = 1'b1;
      end
      default: begin
        res = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered saturating ALU with valid/ready handshake, flags
// register and an iterative shift-add signed multiply.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [3:0]       alu_op,
  input  logic [SHW-1:0]   sh_amt,
  input  logic             upd_flags_on_add,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dst,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [W2-1:0] POS_LIM = W2'(SMAX);
  localparam logic [W2-1:0] NEG_LIM = W2'(SMIN);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  state_e           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [2:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] c_res;
  logic             c_keep;
  logic             c_upd_nv;
  logic             c_upd_z;
  logic             c_ovf;

  alu_sat_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_sat (
    .a        (src0),
    .b        (src1),
    .op       (alu_op),
    .sh_amt   (sh_amt),
    .upd_add  (upd_flags_on_add),
    .res      (c_res),
    .keep_dst (c_keep),
    .upd_nv   (c_upd_nv),
    .upd_z    (c_upd_z),
    .ovf      (c_ovf)
  );

  logic [WIDTH-1:0] abs0;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_res;
  logic             mul_ovf;
  logic             accept;
  logic [WIDTH-1:0] sc_dst;

  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign abs0   = src0[WIDTH-1] ? ('0 - src0) : src0;
  assign abs1   = src1[WIDTH-1] ? ('0 - src1) : src1;
  assign mul_lo = acc_q[WIDTH-1:0];

  always_comb begin
    mul_ovf = 1'b0;
    mul_res = mul_lo;
    if (!neg_q) begin
      mul_ovf = acc_q > POS_LIM;
      mul_res = mul_ovf ? SMAX : mul_lo;
    end else begin
      mul_ovf = acc_q > NEG_LIM;
      mul_res = mul_ovf ? SMIN : ('0 - mul_lo);
    end
  end

  assign in_ready = (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign sc_dst   = c_keep ? dst_q : c_res;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    dst_d       = dst_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q & ~out_ready;
    unique case (state_q)
      S_IDLE: begin
        if (accept && alu_op == ALU_MUL) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          mcand_d  = W2'(abs0);
          mplier_d = abs1;
          acc_d    = '0;
          neg_d    = src0[WIDTH-1] ^ src1[WIDTH-1];
        end else if (accept) begin
          out_valid_d = 1'b1;
          dst_d       = sc_dst;
          if (c_upd_nv) begin
            flags_d[FLAG_N] = sc_dst[WIDTH-1];
            flags_d[FLAG_V] = c_ovf;
          end
          if (c_upd_z) begin
            flags_d[FLAG_Z] = (sc_dst == '0);
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d         = S_IDLE;
          out_valid_d     = 1'b1;
          dst_d           = mul_res;
          flags_d[FLAG_N] = mul_res[WIDTH-1];
          flags_d[FLAG_Z] = (mul_res == '0);
          flags_d[FLAG_V] = mul_ovf;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + (SHW+1)'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      dst_q       <= '0;
      flags_q     <= 3'b000;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      dst_q       <= dst_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);

endmodule
